// File: rtl/lab8_g41_kontrol_if.sv
// Bus bundle between the multi-cycle controller and its instruction source / datapath.
// The slave side is the controller; the master side drives requests and the fetched word.
interface lab8_g41_kontrol_if #(
  parameter int PC_W    = 32,
  parameter int SAYAC_W = 16
);
  logic               baslat;
  logic               durdur;
  logic               komut_gecerli;
  logic [31:0]        komut;
  logic               dal_al;
  logic [PC_W-1:0]    pc;
  logic               komut_hazir;
  logic [31:0]        ir;
  logic [1:0]         imm_sec;
  logic               alu_bas;
  logic               rf_we;
  logic               hata;
  logic               mesgul;
  logic [2:0]         durum;
  logic [SAYAC_W-1:0] komut_sayaci;

  modport master (
    output baslat, durdur, komut_gecerli, komut, dal_al,
    input  pc, komut_hazir, ir, imm_sec, alu_bas, rf_we, hata, mesgul, durum, komut_sayaci
  );

  modport slave (
    input  baslat, durdur, komut_gecerli, komut, dal_al,
    output pc, komut_hazir, ir, imm_sec, alu_bas, rf_we, hata, mesgul, durum, komut_sayaci
  );
endinterface

// File: rtl/lab8_g41_kontrol.sv
// Multi-cycle controller: fetch handshake, opcode classification, ALU sequencing,
// writeback/branch resolution, program counter, retired-instruction counter and sticky error.
module lab8_g41_kontrol #(
  parameter int PC_W         = 32,
  parameter int YURUT_CEVRIM = 1,
  parameter int SAYAC_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  lab8_g41_kontrol_if.slave   bus
);

  typedef enum logic [2:0] {
    BOSTA = 3'd0,
    GETIR = 3'd1,
    COZ   = 3'd2,
    YURUT = 3'd3,
    YAZ   = 3'd4,
    HATA  = 3'd5
  } durum_t;

  localparam logic [3:0]         YURUT_SON = 4'(YURUT_CEVRIM - 1);
  localparam logic [PC_W-1:0]    PC_ADIM   = PC_W'(4);
  localparam logic [SAYAC_W-1:0] SAYAC_BIR = SAYAC_W'(1);

  durum_t             state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [31:0]        ir_reg, ir_next;
  logic [1:0]         imm_sec_reg, imm_sec_next;
  logic               hata_reg, hata_next;
  logic [SAYAC_W-1:0] sayac_reg, sayac_next;
  logic [3:0]         cnt_reg, cnt_next;

  logic               alu_bas, rf_we, komut_hazir, mesgul;
  logic               kod_gecerli;
  logic [1:0]         kod_sec;
  logic [11:0]        dal_ofs;
  logic [PC_W-1:0]    pc_dal, pc_sirali;
  logic               yurut_son;

  // Branch offset is the 12-bit {funct7, rd} field, added unscaled to pc.
  assign dal_ofs   = {ir_reg[31:25], ir_reg[11:7]};
  assign pc_dal    = pc_reg + {{(PC_W-12){dal_ofs[11]}}, dal_ofs};
  assign pc_sirali = pc_reg + PC_ADIM;
  assign yurut_son = (cnt_reg == YURUT_SON);

  always_comb begin
    kod_gecerli = 1'b1;
    kod_sec     = 2'd0;
    case (ir_reg[6:0])
      7'b0000001: kod_sec = 2'd0;
      7'b0000011: kod_sec = 2'd1;
      7'b0000111: kod_sec = 2'd2;
      7'b0001111: kod_sec = 2'd3;
      default:    kod_gecerli = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    imm_sec_next = imm_sec_reg;
    hata_next    = hata_reg;
    sayac_next   = sayac_reg;
    cnt_next     = cnt_reg;
    alu_bas      = 1'b0;
    rf_we        = 1'b0;
    komut_hazir  = 1'b0;
    mesgul       = 1'b0;

    case (state_reg)
      BOSTA: begin
        if (bus.baslat) state_next = GETIR;
      end
      GETIR: begin
        komut_hazir = 1'b1;
        mesgul      = 1'b1;
        if (bus.komut_gecerli) begin
          ir_next    = bus.komut;
          state_next = COZ;
        end
      end
      COZ: begin
        mesgul = 1'b1;
        if (kod_gecerli) begin
          imm_sec_next = kod_sec;
          cnt_next     = 4'd0;
          state_next   = YURUT;
        end else begin
          hata_next  = 1'b1;
          state_next = HATA;
        end
      end
      YURUT: begin
        mesgul  = 1'b1;
        alu_bas = (cnt_reg == 4'd0);
        if (!yurut_son) begin
          cnt_next = cnt_reg + 4'd1;
        end else begin
          cnt_next = 4'd0;
          // Branches retire straight out of YURUT; everything else writes back first.
          if (imm_sec_reg == 2'd3) begin
            pc_next    = bus.dal_al ? pc_dal : pc_sirali;
            sayac_next = sayac_reg + SAYAC_BIR;
            state_next = bus.durdur ? BOSTA : GETIR;
          end else begin
            state_next = YAZ;
          end
        end
      end
      YAZ: begin
        mesgul     = 1'b1;
        rf_we      = (ir_reg[11:7] != 5'd0);
        pc_next    = pc_sirali;
        sayac_next = sayac_reg + SAYAC_BIR;
        state_next = bus.durdur ? BOSTA : GETIR;
      end
      HATA: begin
        state_next = HATA;
      end
      default: begin
        state_next = BOSTA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= BOSTA;
      pc_reg      <= '0;
      ir_reg      <= '0;
      imm_sec_reg <= '0;
      hata_reg    <= 1'b0;
      sayac_reg   <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      imm_sec_reg <= imm_sec_next;
      hata_reg    <= hata_next;
      sayac_reg   <= sayac_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign bus.pc           = pc_reg;
  assign bus.ir           = ir_reg;
  assign bus.imm_sec      = imm_sec_reg;
  assign bus.hata         = hata_reg;
  assign bus.komut_sayaci = sayac_reg;
  assign bus.durum        = state_reg;
  assign bus.alu_bas      = alu_bas;
  assign bus.rf_we        = rf_we;
  assign bus.komut_hazir  = komut_hazir;
  assign bus.mesgul       = mesgul;

endmodule

// File: tb/tb_lab8_g41_kontrol.sv
// Directed bench for lab8_g41_kontrol: a per-cycle vector table on a 1-cycle-ALU instance,
// plus hand-written sequences on a 3-cycle-ALU instance.
module tb_lab8_g41_kontrol;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lab8_g41_kontrol_if #(.PC_W(32), .SAYAC_W(16)) bus1 ();
  lab8_g41_kontrol_if #(.PC_W(32), .SAYAC_W(16)) bus3 ();

  lab8_g41_kontrol #(.PC_W(32), .YURUT_CEVRIM(1), .SAYAC_W(16)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );
  lab8_g41_kontrol #(.PC_W(32), .YURUT_CEVRIM(3), .SAYAC_W(16)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave)
  );

  localparam logic [31:0] K_R   = 32'b0100000_10100_00110_001_10011_0000001;
  localparam logic [31:0] K_BF  = 32'b0000000_01011_11001_001_01000_0001111;
  localparam logic [31:0] K_BB  = 32'b1111111_01011_11001_001_11100_0001111;
  localparam logic [31:0] K_I0  = 32'b000000001011_11001_001_00000_0000011;
  localparam logic [31:0] K_ILL = 32'b0100000_10100_00110_001_10011_0010001;

  typedef struct {
    logic        rst, bas, dur, gec;
    logic [31:0] kom;
    logic        dal;
    logic [2:0]  e_durum;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic [1:0]  e_imm;
    logic        e_alu, e_we, e_hata;
    logic [15:0] e_sayac;
    logic        e_hazir, e_mes;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(input logic rst, bas, dur, gec, input logic [31:0] kom, input logic dal,
                              input logic [2:0] du, input logic [31:0] pc, input logic [31:0] ir,
                              input logic [1:0] imm, input logic alu, we, ha, input logic [15:0] sy,
                              input logic hz, ms);
    vec_t v;
    v.rst = rst; v.bas = bas; v.dur = dur; v.gec = gec; v.kom = kom; v.dal = dal;
    v.e_durum = du; v.e_pc = pc; v.e_ir = ir; v.e_imm = imm; v.e_alu = alu; v.e_we = we;
    v.e_hata = ha; v.e_sayac = sy; v.e_hazir = hz; v.e_mes = ms;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h expected=%0h", nm, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus1.baslat = 0; bus1.durdur = 0; bus1.komut_gecerli = 0; bus1.komut = '0; bus1.dal_al = 0;
    bus3.baslat = 0; bus3.durdur = 0; bus3.komut_gecerli = 0; bus3.komut = '0; bus3.dal_al = 0;

    //                 rst bas dur gec kom    dal  durum pc  ir     imm alu we ha sayac hz ms
    vecs.push_back(mk(1, 0, 0, 0, '0,    0,   0, 0,  '0,    0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, '0,    0,   1, 0,  '0,    0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, K_R,   0,   2, 0,  K_R,   0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, K_ILL, 0,   3, 0,  K_R,   0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, K_ILL, 0,   4, 0,  K_R,   0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   1, 4,  K_R,   0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, K_BF,  0,   2, 4,  K_BF,  0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   3, 4,  K_BF,  3, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    1,   1, 12, K_BF,  3, 0, 0, 0, 2, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, K_BB,  0,   2, 12, K_BB,  3, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   3, 12, K_BB,  3, 1, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    1,   1, 8,  K_BB,  3, 0, 0, 0, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, K_BF,  0,   2, 8,  K_BF,  3, 0, 0, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   3, 8,  K_BF,  3, 1, 0, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   1, 12, K_BF,  3, 0, 0, 0, 4, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, K_I0,  0,   2, 12, K_I0,  3, 0, 0, 0, 4, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   3, 12, K_I0,  1, 1, 0, 0, 4, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   4, 12, K_I0,  1, 0, 0, 0, 4, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   1, 16, K_I0,  1, 0, 0, 0, 5, 1, 1));
    for (int s = 0; s < 5; s++)
      vecs.push_back(mk(0, 0, 0, 0, K_ILL, 0, 1, 16, K_I0,  1, 0, 0, 0, 5, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, K_R,   0,   2, 16, K_R,   1, 0, 0, 0, 5, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   3, 16, K_R,   0, 1, 0, 0, 5, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   4, 16, K_R,   0, 0, 1, 0, 5, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, '0,    0,   0, 20, K_R,   0, 0, 0, 0, 6, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, '0,    0,   1, 20, K_R,   0, 0, 0, 0, 6, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, K_ILL, 0,   2, 20, K_ILL, 0, 0, 0, 0, 6, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   5, 20, K_ILL, 0, 0, 0, 1, 6, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, '0,    0,   5, 20, K_ILL, 0, 0, 0, 1, 6, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, K_R,   0,   5, 20, K_ILL, 0, 0, 0, 1, 6, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, '0,    0,   0, 0,  '0,    0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, '0,    0,   1, 0,  '0,    0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, K_R,   0,   2, 0,  K_R,   0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   3, 0,  K_R,   0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, '0,    0,   0, 0,  '0,    0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, '0,    0,   0, 0,  '0,    0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset              = vecs[i].rst;
      bus1.baslat        = vecs[i].bas;
      bus1.durdur        = vecs[i].dur;
      bus1.komut_gecerli = vecs[i].gec;
      bus1.komut         = vecs[i].kom;
      bus1.dal_al        = vecs[i].dal;
      step();
      chk("durum", i, 32'(bus1.durum), 32'(vecs[i].e_durum));
      chk("pc", i, bus1.pc, vecs[i].e_pc);
      chk("ir", i, bus1.ir, vecs[i].e_ir);
      chk("imm_sec", i, 32'(bus1.imm_sec), 32'(vecs[i].e_imm));
      chk("alu_bas", i, 32'(bus1.alu_bas), 32'(vecs[i].e_alu));
      chk("rf_we", i, 32'(bus1.rf_we), 32'(vecs[i].e_we));
      chk("hata", i, 32'(bus1.hata), 32'(vecs[i].e_hata));
      chk("komut_sayaci", i, 32'(bus1.komut_sayaci), 32'(vecs[i].e_sayac));
      chk("komut_hazir", i, 32'(bus1.komut_hazir), 32'(vecs[i].e_hazir));
      chk("mesgul", i, 32'(bus1.mesgul), 32'(vecs[i].e_mes));
      $display("vec %0d: durum=%0d pc=%0d ir=%08h imm=%0d alu=%0b we=%0b hata=%0b sayac=%0d",
               i, bus1.durum, bus1.pc, bus1.ir, bus1.imm_sec, bus1.alu_bas, bus1.rf_we,
               bus1.hata, bus1.komut_sayaci);
    end
    reset = 1'b0;

    // Three-cycle ALU: R-type, alu_bas only on the first YURUT cycle.
    bus3.baslat = 1; step();
    chk("c3_getir", 100, 32'(bus3.durum), 32'd1);
    bus3.baslat = 0; bus3.komut_gecerli = 1; bus3.komut = K_R; step();
    chk("c3_coz", 101, 32'(bus3.durum), 32'd2);
    bus3.komut_gecerli = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("c3_yurut_durum", 102 + c, 32'(bus3.durum), 32'd3);
      chk("c3_alu_bas", 102 + c, 32'(bus3.alu_bas), (c == 0) ? 32'd1 : 32'd0);
    end
    step();
    chk("c3_yaz", 105, 32'(bus3.durum), 32'd4);
    chk("c3_rf_we", 105, 32'(bus3.rf_we), 32'd1);
    step();
    chk("c3_ret_durum", 106, 32'(bus3.durum), 32'd1);
    chk("c3_ret_pc", 106, bus3.pc, 32'd4);
    chk("c3_ret_sayac", 106, 32'(bus3.komut_sayaci), 32'd1);
    $display("c3 R-type: durum=%0d pc=%0d sayac=%0d", bus3.durum, bus3.pc, bus3.komut_sayaci);

    // Three-cycle ALU: backward taken branch from pc=4 lands on 0.
    bus3.komut_gecerli = 1; bus3.komut = K_BB; step();
    chk("c3b_coz", 107, 32'(bus3.durum), 32'd2);
    bus3.komut_gecerli = 0;
    step(); step(); step();
    chk("c3b_yurut", 108, 32'(bus3.durum), 32'd3);
    chk("c3b_alu_son", 108, 32'(bus3.alu_bas), 32'd0);
    bus3.dal_al = 1; step();
    bus3.dal_al = 0;
    chk("c3b_durum", 109, 32'(bus3.durum), 32'd1);
    chk("c3b_pc", 109, bus3.pc, 32'd0);
    chk("c3b_sayac", 109, 32'(bus3.komut_sayaci), 32'd2);
    chk("c3b_we", 109, 32'(bus3.rf_we), 32'd0);
    $display("c3 branch: durum=%0d pc=%0d sayac=%0d", bus3.durum, bus3.pc, bus3.komut_sayaci);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lab8_g41_kontrol.md
Name: lab8_g41_kontrol

Overview:
Multi-cycle controller that sequences the instruction decoder / register file datapath one instruction at a time.
- Handshakes with an instruction source and latches the instruction word.
- Classifies the opcode into R, I, U or B format.
- Pulses the ALU start, then either pulses the register-file write enable or resolves a branch.
- Maintains the program counter, a retired-instruction counter and a sticky error flag.

Parameters:
PC_W, 32, program counter width in bits
YURUT_CEVRIM, 1, cycles spent in YURUT (ALU latency model); legal range 1..15
SAYAC_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
baslat  in  1  start request, sampled only in BOSTA
durdur  in  1  stop request, sampled on the last cycle of an instruction
komut_gecerli  in  1  instruction source has a valid word on komut
komut  in  32  instruction word: [31:25] funct7, [24:20] rs2, [19:15] rs1, [14:12] funct3, [11:7] rd, [6:0] opcode
dal_al  in  1  branch-taken flag from ALU, sampled on the last YURUT cycle
pc  out  PC_W  current instruction address
komut_hazir  out  1  controller accepts an instruction (high exactly while in GETIR)
ir  out  32  latched instruction word
imm_sec  out  2  format select: 0 R, 1 I, 2 U, 3 B
alu_bas  out  1  ALU start, one-cycle pulse
rf_we  out  1  register-file write enable, one-cycle pulse
hata  out  1  sticky illegal-opcode flag
mesgul  out  1  high in GETIR, COZ, YURUT, YAZ
durum  out  3  state code
komut_sayaci  out  SAYAC_W  retired instructions

Behaviour:
- Reset is synchronous: on a rising edge with reset=1 the block enters BOSTA and sets every output to 0 (pc, ir, imm_sec, alu_bas, rf_we, hata, komut_sayaci, durum=0). Reset takes priority from any state, mid-instruction included; no rf_we or alu_bas pulse is produced on that edge or the next cycle.
- State codes: BOSTA=0, GETIR=1, COZ=2, YURUT=3, YAZ=4, HATA=5. Codes 6 and 7 are unreachable; if entered, the next state is BOSTA.
- BOSTA: when baslat=1 -> GETIR. pc is not modified.
- GETIR:
  - komut_hazir=1.
  - On komut_gecerli=1: ir<=komut, go to COZ.
  - On komut_gecerli=0: stay in GETIR indefinitely, ir unchanged.
- COZ: decode ir[6:0].
  - 0000001 -> imm_sec=0 (R).
  - 0000011 -> imm_sec=1 (I).
  - 0000111 -> imm_sec=2 (U).
  - 0001111 -> imm_sec=3 (B).
  - Any valid opcode -> YURUT. Any other opcode -> HATA, with hata<=1 on the same edge.
  - imm_sec is registered on the COZ->YURUT edge and holds until the next COZ.
- YURUT:
  - alu_bas=1 on the first YURUT cycle only.
  - An internal 4-bit counter holds the state for YURUT_CEVRIM cycles.
  - On the last cycle, R/I/U go to YAZ.
  - On the last cycle, B goes to GETIR (or BOSTA if durdur=1) and retires:
    - dal_al=1: pc <= pc + sext12({ir[31:25], ir[11:7]}), modulo 2^PC_W.
    - dal_al=0: pc <= pc + 4.
- YAZ:
  - rf_we=1 for exactly one cycle if ir[11:7]!=0; if rd=0, rf_we stays 0 but the instruction still retires.
  - pc <= pc+4 (modulo 2^PC_W).
  - Next state GETIR, or BOSTA if durdur=1.
- Retirement:
  - Happens on leaving YAZ, or on leaving YURUT for a B instruction.
  - komut_sayaci increments by 1 and wraps from 2^SAYAC_W-1 to 0.
- HATA:
  - Terminal until reset; baslat is ignored.
  - mesgul=0, all pulses 0.
  - pc and ir hold the faulting instruction's values; komut_sayaci is not incremented.
- Timing with YURUT_CEVRIM=1 and komut_gecerli constantly 1: 4 cycles per R/I/U instruction (GETIR, COZ, YURUT, YAZ) and 3 cycles per B instruction.
- komut is ignored outside GETIR.

Test Plan:
- R-type writeback: after reset, baslat=1 for 1 cycle, komut=32'b0100000_10100_00110_001_10011_0000001, komut_gecerli=1 -> sequence GETIR,COZ,YURUT,YAZ. alu_bas is high in YURUT and rf_we is high in YAZ. Then pc=4, komut_sayaci=1, imm_sec=0.
- Taken branches:
  - Forward: pc=4, komut=32'b0000000_01011_11001_001_01000_0001111 (offset +8), dal_al=1 -> pc=12, no rf_we pulse, 3 cycles.
  - Backward: komut with funct7=1111111, rd=11100 (offset -4) -> pc=8.
  - Not taken: dal_al=0 -> pc+4.
- Flow control:
  - rd=0: I-type komut=32'b000000001011_11001_001_00000_0000011 -> rf_we stays 0, pc+=4, komut_sayaci increments.
  - Handshake stall: komut_gecerli=0 for 5 cycles in GETIR -> durum=1, komut_hazir=1 and ir unchanged throughout; then 1 -> COZ next cycle.
  - YURUT_CEVRIM=3: alu_bas high only on the first of 3 YURUT cycles.
- Illegal opcode: komut=32'b0100000_10100_00110_001_10011_0010001 -> hata=1, durum=5 after COZ.
  - baslat=1 is ignored and the state persists.
  - reset=1 for 1 cycle -> hata=0, durum=0, pc=0.
- Stop and reset mid-operation:
  - durdur=1 during YAZ -> BOSTA with pc advanced and mesgul=0.
  - reset asserted in YURUT -> next cycle durum=0, no rf_we pulse, komut_sayaci=0.
